// File: rtl/dma_stream_engine.sv
// DMA stream engine: reads BRAM u0 words into a show-ahead FIFO that feeds the
// accelerator stream, and writes the accelerator result stream into BRAM u1.
module dma_stream_engine #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [LEN_W-1:0]  src_len,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  dst_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              dma_r_ready,
    output logic [ADDR_W-1:0] dma_r_addr,
    input  logic              dma_r_ack,
    input  logic              bram_rd_valid,
    input  logic [DATA_W-1:0] bram_rd_data,
    output logic              dma_w_valid,
    output logic [ADDR_W-1:0] dma_w_addr,
    output logic [DATA_W-1:0] dma_w_data,
    output logic              sm_tvalid,
    output logic [DATA_W-1:0] sm_tdata,
    output logic              sm_tlast,
    input  logic              sm_tready,
    input  logic              ss_tvalid,
    input  logic [DATA_W-1:0] ss_tdata,
    input  logic              ss_tlast,
    output logic              ss_tready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0]   rd_rem_q, rd_rem_d;
    logic [CNT_W-1:0]   outst_q, outst_d;
    logic [LEN_W-1:0]   str_rem_q, str_rem_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [LEN_W-1:0]   wr_rem_q, wr_rem_d;
    logic               ws_valid_q, ws_valid_d;
    logic [ADDR_W-1:0]  ws_addr_q, ws_addr_d;
    logic [DATA_W-1:0]  ws_data_q, ws_data_d;
    logic               err_q, err_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [DATA_W-1:0]  fifo_mem_q [FIFO_DEPTH];

    logic               run;
    logic [CNT_W:0]     occ;
    logic               rd_req, rd_fire, push, pop, ss_rdy, ss_hs, all_clear, is_last;

    // Reads in flight count against FIFO space so returns can never overflow it.
    always_comb begin
        run       = (state_q == S_RUN);
        occ       = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
        rd_req    = run && (rd_rem_q != '0) && (occ < (CNT_W+1)'(FIFO_DEPTH));
        rd_fire   = rd_req && dma_r_ack;
        push      = run && bram_rd_valid && (outst_q != '0);
        pop       = (fifo_cnt_q != '0) && sm_tready;
        ss_rdy    = run && (wr_rem_q != '0);
        ss_hs     = ss_tvalid && ss_rdy;
        is_last   = (wr_rem_q == LEN_W'(1));
        all_clear = (rd_rem_q == '0) && (outst_q == '0) && (fifo_cnt_q == '0) &&
                    (str_rem_q == '0) && (wr_rem_q == '0) && !ws_valid_q;
    end

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        rd_rem_d   = rd_rem_q;
        outst_d    = outst_q;
        str_rem_d  = str_rem_q;
        wr_addr_d  = wr_addr_q;
        wr_rem_d   = wr_rem_q;
        ws_valid_d = 1'b0;
        ws_addr_d  = ws_addr_q;
        ws_data_d  = ws_data_q;
        err_d      = err_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop) fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
        else if (!push && pop) fifo_cnt_d = fifo_cnt_q - CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rd_addr_d = src_base;
                    rd_rem_d  = src_len;
                    str_rem_d = src_len;
                    wr_addr_d = dst_base;
                    wr_rem_d  = dst_len;
                    outst_d   = '0;
                    err_d     = 1'b0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (rd_fire) begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    rd_rem_d  = rd_rem_q - LEN_W'(1);
                end
                if (rd_fire && !push) outst_d = outst_q + CNT_W'(1);
                else if (!rd_fire && push) outst_d = outst_q - CNT_W'(1);
                if (pop && (str_rem_q != '0)) str_rem_d = str_rem_q - LEN_W'(1);
                // Write address/count advance at acceptance so ss_tready drops
                // right after the final word instead of one cycle late.
                if (ss_hs) begin
                    ws_valid_d = 1'b1;
                    ws_addr_d  = wr_addr_q;
                    ws_data_d  = ss_tdata;
                    wr_addr_d  = wr_addr_q + ADDR_W'(1);
                    wr_rem_d   = wr_rem_q - LEN_W'(1);
                    if (ss_tlast != is_last) err_d = 1'b1;
                end
                if (all_clear) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            rd_addr_q  <= '0;
            rd_rem_q   <= '0;
            outst_q    <= '0;
            str_rem_q  <= '0;
            wr_addr_q  <= '0;
            wr_rem_q   <= '0;
            ws_valid_q <= 1'b0;
            ws_addr_q  <= '0;
            ws_data_q  <= '0;
            err_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            rd_rem_q   <= rd_rem_d;
            outst_q    <= outst_d;
            str_rem_q  <= str_rem_d;
            wr_addr_q  <= wr_addr_d;
            wr_rem_q   <= wr_rem_d;
            ws_valid_q <= ws_valid_d;
            ws_addr_q  <= ws_addr_d;
            ws_data_q  <= ws_data_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Storage only; validity is tracked by the pointers and count.
    always_ff @(posedge wb_clk_i) begin
        if (push) fifo_mem_q[wr_ptr_q] <= bram_rd_data;
    end

    assign busy        = run;
    assign done        = (state_q == S_DONE);
    assign err         = err_q;
    assign dma_r_ready = rd_req;
    assign dma_r_addr  = rd_addr_q;
    assign dma_w_valid = ws_valid_q;
    assign dma_w_addr  = ws_addr_q;
    assign dma_w_data  = ws_data_q;
    assign sm_tvalid   = (fifo_cnt_q != '0);
    assign sm_tdata    = sm_tvalid ? fifo_mem_q[rd_ptr_q] : '0;
    assign sm_tlast    = sm_tvalid && (str_rem_q == LEN_W'(1));
    assign ss_tready   = ss_rdy;

endmodule

// File: tb/tb_dma_stream_engine.sv
// Directed bench for dma_stream_engine: BRAM read model with 2-cycle latency,
// accelerator sink/source, and hand-computed expectations per job.
module tb_dma_stream_engine;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        start = 1'b0;
    logic [12:0] src_base = '0, dst_base = '0, src_len = '0, dst_len = '0;
    logic        busy, done, err, dma_r_ready, dma_w_valid, sm_tvalid, sm_tlast, ss_tready;
    logic [12:0] dma_r_addr, dma_w_addr;
    logic [31:0] dma_w_data, sm_tdata;
    logic        dma_r_ack = 1'b0, bram_rd_valid = 1'b0, sm_tready = 1'b0;
    logic        ss_tvalid = 1'b0, ss_tlast = 1'b0;
    logic [31:0] bram_rd_data = '0, ss_tdata = '0;

    dma_stream_engine #(.ADDR_W(13), .DATA_W(32), .LEN_W(13), .FIFO_DEPTH(4)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start),
        .src_base(src_base), .src_len(src_len), .dst_base(dst_base), .dst_len(dst_len),
        .busy(busy), .done(done), .err(err),
        .dma_r_ready(dma_r_ready), .dma_r_addr(dma_r_addr), .dma_r_ack(dma_r_ack),
        .bram_rd_valid(bram_rd_valid), .bram_rd_data(bram_rd_data),
        .dma_w_valid(dma_w_valid), .dma_w_addr(dma_w_addr), .dma_w_data(dma_w_data),
        .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, c0 = 0;
    int ack_mode = 0, stall_from = -1, stall_to = -1;
    logic p1_v = 1'b0, p2_v = 1'b0;
    logic [12:0] p1_a = '0, p2_a = '0;
    logic [31:0] ss_dat [8];
    int ss_n = 0, ss_last = -1, ss_idx = 0;
    logic [12:0] rq_addr [$];
    int          rq_cyc [$];
    logic [31:0] sm_dat [$];
    logic        sm_lst [$];
    logic [12:0] w_addr [$];
    logic [31:0] w_dat [$];
    int          w_cyc [$];
    int          hs_cyc [$];
    int hold_bad = 0, occ = 0, occ_max = 0, done_cnt = 0, done_cyc = 0;
    logic prev_unacked = 1'b0;
    logic [12:0] prev_addr = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_rec();
        rq_addr.delete(); rq_cyc.delete(); sm_dat.delete(); sm_lst.delete();
        w_addr.delete(); w_dat.delete(); w_cyc.delete(); hs_cyc.delete();
        hold_bad = 0; occ = 0; occ_max = 0; done_cnt = 0; done_cyc = 0;
        prev_unacked = 1'b0; ss_idx = 0;
    endtask

    // Drives this cycle's inputs from the visible outputs and records traffic.
    task automatic proc_cycle();
        bram_rd_valid = p2_v;
        bram_rd_data  = 32'hA500_0000 | {19'd0, p2_a};
        p2_v = p1_v; p2_a = p1_a;
        if (prev_unacked && dma_r_addr !== prev_addr) hold_bad++;
        dma_r_ack = (ack_mode == 0) ? 1'b1 : (cyc % 2 == 0);
        p1_v = dma_r_ready & dma_r_ack;
        p1_a = dma_r_addr;
        if (p1_v) begin rq_addr.push_back(dma_r_addr); rq_cyc.push_back(cyc); occ++; end
        prev_unacked = dma_r_ready & ~dma_r_ack;
        prev_addr = dma_r_addr;
        sm_tready = !(cyc >= stall_from && cyc < stall_to);
        if (sm_tvalid && sm_tready) begin
            sm_dat.push_back(sm_tdata); sm_lst.push_back(sm_tlast); occ--;
        end
        if (occ > occ_max) occ_max = occ;
        ss_tvalid = (ss_idx < ss_n);
        ss_tdata  = (ss_idx < 8) ? ss_dat[ss_idx] : 32'd0;
        ss_tlast  = (ss_idx == ss_last);
        if (ss_tvalid && ss_tready) begin hs_cyc.push_back(cyc); ss_idx++; end
        if (dma_w_valid) begin
            w_addr.push_back(dma_w_addr); w_dat.push_back(dma_w_data); w_cyc.push_back(cyc);
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
    endtask

    task automatic step();
        @(posedge wb_clk_i);
        #1;
        cyc++;
        start = 1'b0;
        proc_cycle();
    endtask

    task automatic launch(input logic [12:0] sb, input logic [12:0] sl,
                          input logic [12:0] db, input logic [12:0] dl);
        src_base = sb; src_len = sl; dst_base = db; dst_len = dl;
        start = 1'b1;
        c0 = cyc;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done_cnt == 0 && k < 200) begin step(); k++; end
        chk({tag, "_done_seen"}, done_cnt, 1);
        step();
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        wb_rst_i = 1'b1;
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_r_ready", dma_r_ready, 0);
        chk("rst_w_valid", dma_w_valid, 0);
        chk("rst_sm_tvalid", sm_tvalid, 0);
        chk("rst_sm_tlast", sm_tlast, 0);
        chk("rst_ss_tready", ss_tready, 0);
        chk("rst_r_addr", dma_r_addr, 0);
        chk("rst_w_addr", dma_w_addr, 0);
        chk("rst_w_data", dma_w_data, 0);
        chk("rst_sm_tdata", sm_tdata, 0);
        wb_rst_i = 1'b0;
        step();

        // Job 1: 8 reads from 0x010, ack always, sink always ready.
        clear_rec();
        launch(13'h010, 13'd8, 13'h0, 13'd0);
        step();
        chk("j1_busy_c1", busy, 1);
        chk("j1_r_ready_c1", dma_r_ready, 1);
        chk("j1_ss_tready_c1", ss_tready, 0);
        wait_done("j1");
        chk("j1_done_cyc", done_cyc - c0, 13);
        chk("j1_nreq", rq_addr.size(), 8);
        chk("j1_nword", sm_dat.size(), 8);
        for (int i = 0; i < 8 && i < rq_addr.size(); i++) begin
            chk("j1_req_addr", rq_addr[i], 13'h010 + i);
            chk("j1_req_cyc", rq_cyc[i] - c0, 1 + i);
        end
        for (int i = 0; i < 8 && i < sm_dat.size(); i++) begin
            chk("j1_word", sm_dat[i], 32'hA500_0010 + i);
            chk("j1_tlast", sm_lst[i], (i == 7));
        end

        // Job 2: same job, ack on alternate cycles, sink stalls for 5 cycles.
        clear_rec();
        ack_mode = 1;
        launch(13'h010, 13'd8, 13'h0, 13'd0);
        stall_from = c0 + 5; stall_to = c0 + 10;
        wait_done("j2");
        ack_mode = 0; stall_from = -1; stall_to = -1;
        chk("j2_addr_hold", hold_bad, 0);
        chk("j2_occ_le4", (occ_max <= 4), 1);
        chk("j2_nreq", rq_addr.size(), 8);
        chk("j2_nword", sm_dat.size(), 8);
        for (int i = 0; i < 8 && i < sm_dat.size(); i++) begin
            chk("j2_word", sm_dat[i], 32'hA500_0010 + i);
            chk("j2_tlast", sm_lst[i], (i == 7));
        end

        // Job 3: 4 results written from 0x1FFE, wrapping through 0.
        clear_rec();
        ss_dat[0] = 32'h1111_0001; ss_dat[1] = 32'h2222_0002;
        ss_dat[2] = 32'h3333_0003; ss_dat[3] = 32'h4444_0004;
        ss_n = 4; ss_last = 3;
        launch(13'h0, 13'd0, 13'h1FFE, 13'd4);
        wait_done("j3");
        chk("j3_done_cyc", done_cyc - c0, 7);
        chk("j3_err", err, 0);
        chk("j3_nwrite", w_addr.size(), 4);
        chk("j3_first_hs", (hs_cyc.size() > 0) ? hs_cyc[0] - c0 : -1, 1);
        for (int i = 0; i < 4 && i < w_addr.size() && i < hs_cyc.size(); i++) begin
            chk("j3_w_addr", w_addr[i], (13'h1FFE + i) & 13'h1FFF);
            chk("j3_w_data", w_dat[i], ss_dat[i]);
            chk("j3_w_lat", w_cyc[i] - hs_cyc[i], 1);
        end
        chk("j3_rd_traffic", rq_addr.size(), 0);

        // Job 4: 3 results with tlast on the 2nd -> err, all writes still occur.
        clear_rec();
        ss_n = 3; ss_last = 1;
        launch(13'h0, 13'd0, 13'h100, 13'd3);
        wait_done("j4");
        chk("j4_err", err, 1);
        chk("j4_nwrite", w_addr.size(), 3);
        for (int i = 0; i < 3 && i < w_addr.size(); i++)
            chk("j4_w_addr", w_addr[i], 13'h100 + i);

        // Job 5: zero lengths; err from job 4 clears on start.
        clear_rec();
        ss_n = 0; ss_last = -1;
        launch(13'h0, 13'd0, 13'h0, 13'd0);
        step();
        chk("j5_busy_c1", busy, 1);
        chk("j5_err_clr", err, 0);
        wait_done("j5");
        chk("j5_done_cyc", done_cyc - c0, 2);
        chk("j5_nreq", rq_addr.size(), 0);
        chk("j5_nwrite", w_addr.size(), 0);

        // Job 6: reset during outstanding reads, then a fresh 2-word job.
        clear_rec();
        launch(13'h020, 13'd8, 13'h0, 13'd0);
        repeat (3) step();
        wb_rst_i = 1'b1;
        step();
        wb_rst_i = 1'b0;
        clear_rec();
        repeat (4) step();
        chk("j6_idle_busy", busy, 0);
        chk("j6_stale_drop", sm_dat.size(), 0);
        launch(13'h040, 13'd2, 13'h0, 13'd0);
        wait_done("j6");
        chk("j6_nword", sm_dat.size(), 2);
        for (int i = 0; i < 2 && i < sm_dat.size(); i++) begin
            chk("j6_word", sm_dat[i], 32'hA500_0040 + i);
            chk("j6_tlast", sm_lst[i], (i == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dma_stream_engine.md
# dma_stream_engine

DMA initiator on the far side of the BRAM arbiter.
- Read path: reads raw words from BRAM u0 through the arbiter's DMA read port and streams them to the accelerator.
- Write path: accepts the accelerator's result stream and writes it into BRAM u1 through the arbiter's DMA write port.
- Read and write paths run concurrently. Software sets the job through a start pulse plus base and length registers; the block reports `busy`, a `done` pulse and an error flag.

## Interface
- `ADDR_W`, 13: BRAM word-address width.
- `DATA_W`, 32: data width.
- `LEN_W`, 13: width of the length fields.
- `FIFO_DEPTH`, 4: depth of the read-return FIFO. Power of 2, 2..16.
- `wb_clk_i`  in  1  clock. The only clock.
- `wb_rst_i`  in  1  reset. Synchronous, active-high.
- `start`  in  1  one-cycle job start. Sampled only in IDLE.
- `src_base`  in  ADDR_W  first u0 word address.
- `src_len`  in  LEN_W  number of words to read and stream out.
- `dst_base`  in  ADDR_W  first u1 word address.
- `dst_len`  in  LEN_W  number of result words to accept and write.
- `busy`  out  1  high from the cycle after `start` until the cycle `done` fires.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky `ss_tlast` mismatch flag. Cleared by the next accepted `start`.
- `dma_r_ready`  out  1  read request to the arbiter.
- `dma_r_addr`  out  ADDR_W  read address.
- `dma_r_ack`  in  1  read request accepted this cycle. Combinational from the arbiter.
- `bram_rd_valid`  in  1  u0 read data returned for the DMA reader.
- `bram_rd_data`  in  DATA_W  returned data.
- `dma_w_valid`  out  1  write request. The arbiter always accepts it in the same cycle.
- `dma_w_addr`  out  ADDR_W  write address.
- `dma_w_data`  out  DATA_W  write data.
- `sm_tvalid`, `sm_tdata`, `sm_tlast`  out  1/DATA_W/1  stream to the accelerator.
- `sm_tready`  in  1  accelerator ready.
- `ss_tvalid`, `ss_tdata`, `ss_tlast`  in  1/DATA_W/1  result stream from the accelerator.
- `ss_tready`  out  1  block ready for a result word.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - On `start`, latch the bases and lengths into read/write address counters and the remaining-read, remaining-stream and remaining-write counters.
  - Clear `err` and go to RUN.
- IDLE with `src_len`=0 and `dst_len`=0: go to RUN, which completes immediately.
- `start` while `busy` is ignored.
- Read issue (RUN):
  - `dma_r_ready` = (reads remaining>0) & (outstanding + FIFO occupancy < FIFO_DEPTH).
  - On `dma_r_ack`, `dma_r_addr` increments, reads remaining decrements and outstanding increments.
  - `dma_r_addr` holds while the request is not acked. The arbiter gives CPU writes priority, so acks may be withheld for arbitrary cycles.
- Read return:
  - `bram_rd_valid` pushes `bram_rd_data` into the FIFO and decrements outstanding.
  - `bram_rd_valid` with outstanding=0, or in IDLE/DONE, is dropped.
- Stream out:
  - `sm_tvalid` = FIFO not empty (show-ahead head).
  - Pop on `sm_tvalid & sm_tready`.
  - `sm_tlast` = 1 on the word where stream-remaining=1.
- Write path:
  - `ss_tready` = RUN & writes remaining>0.
  - Each `ss_tvalid & ss_tready` registers the data and address into the write stage.
  - `dma_w_valid` pulses the next cycle. `dma_w_addr` then increments and writes remaining decrements.
- `err` sets when `ss_tlast`=1 on any accepted word other than the last, or `ss_tlast`=0 on the last accepted word.
- RUN→DONE when reads remaining=0, outstanding=0, FIFO empty, stream remaining=0, writes remaining=0 and the write stage is empty.
- DONE: `done`=1 for one cycle, then IDLE.
- Addresses wrap modulo 2^ADDR_W. Lengths are unsigned. Counters never underflow.

## Timing
- Reset values:
  - `busy`, `done`, `err`, `dma_r_ready`, `dma_w_valid`, `sm_tvalid`, `sm_tlast`, `ss_tready` = 0.
  - `dma_r_addr`, `dma_w_addr`, `dma_w_data`, `sm_tdata` = 0.
  - FIFO empty, all counters 0, state IDLE.
- Reset mid-job aborts the job immediately. In-flight read returns after reset are dropped.
- `start` at cycle 0: `busy`=1 and `dma_r_ready`=1 at cycle 1 (if `src_len`>0). `ss_tready`=1 at cycle 1 (if `dst_len`>0).
- With an ack every cycle and `sm_tready`=1, one word streams per cycle. The FIFO never overflows for any read latency.
- Write latency: 1 cycle from the `ss` handshake to `dma_w_valid`. Full throughput.
- `done` asserts 1 cycle after the last completion condition becomes true, and `busy` drops in the same cycle.

## Test plan
- `src_base`=0x010, `src_len`=8, read latency 2, acks always high, `sm_tready`=1:
  - Requested addresses are 0x010..0x017 on 8 consecutive cycles.
  - 8 words stream in order, with `sm_tlast` on word 8.
- Same job with `dma_r_ack` low on alternate cycles and `sm_tready` low for 5 cycles:
  - `dma_r_addr` holds while unacked.
  - The outstanding + FIFO count never exceeds 4.
  - No word is lost or duplicated.
- `dst_base`=0x1FFE, `dst_len`=4, 4 results with `ss_tlast` on the 4th:
  - Writes land at 0x1FFE, 0x1FFF, 0x0000, 0x0001, each 1 cycle after its handshake.
  - `err`=0.
- `dst_len`=3 with `ss_tlast` on result 2 → `err`=1 at completion, and all 3 writes still occur.
- `src_len`=0, `dst_len`=0 → `done` pulses with no read or write traffic.
- Assert `wb_rst_i` during outstanding reads, then start a new job with `src_len`=2:
  - Stale returns are dropped.
  - Only the 2 new words stream.
